idu_stage: RTL and testbench
============================

// Module: idu_stage
// PURPOSE
//  Decode stage directly downstream of instruction fetch. Registers one fetched
//  {pc, inst} beat per valid/ready handshake and decodes RV32I/RV32E fields.
//  Produces register indices, sign-extended immediate, instruction class, and
//  illegal/halt flags for the execute stage.
//  Owns the sim-halt FSM: after EBREAK leaves the stage, no further fetch is accepted.
// PARAMETERS
//  ADDR_WIDTH  32            pc width
//  DATA_WIDTH  32            instruction/immediate width
//  RVE         0             1: 16 GPRs; any rs1/rs2/rd index >= 16 is illegal
//  RESET_PC    32'h8000_0000 reset value of out_pc
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   reset; asynchronous, active-high
//  in_valid   in   1   fetch beat present
//  in_ready   out  1   stage can accept a beat this cycle
//  in_pc      in   32  pc of fetched instruction
//  in_inst    in   32  fetched instruction word
//  flush      in   1   redirect from execute; kill held beat and incoming beat
//  out_valid  out  1   decoded beat present
//  out_ready  in   1   execute accepts beat
//  out_pc     out  32  registered pc
//  out_inst   out  32  registered raw instruction
//  out_class  out  4   0 ILL,1 LUI,2 AUIPC,3 JAL,4 JALR,5 BRANCH,6 LOAD,7 STORE,8 OPIMM,9 OP,10 SYSTEM
//  out_funct3 out  3   inst[14:12]
//  out_alt    out  1   inst[30] (SUB/SRA select)
//  out_rs1    out  5   inst[19:15]
//  out_rs2    out  5   inst[24:20]
//  out_rd     out  5   inst[11:7]
//  out_rd_wen out  1   rd write enable
//  out_imm    out  32  sign-extended immediate (I/S/B/U/J per class; 0 for OP/ILL)
//  out_illegal out 1   beat is an illegal instruction
//  out_halt   out  1   beat is EBREAK (32'h0010_0073)
// BEHAVIOUR
//  Reset: out_valid=0, out_pc=RESET_PC, out_inst=32'h0000_0013, all other
//   outputs 0, FSM=RUN. Reset mid-operation discards the held beat at once.
//  in_ready = (state==RUN) && (!out_valid || out_ready). Combinational; never
//   depends on in_valid.
//  Capture when in_valid && in_ready && !flush: all out_* loaded next edge
//   (latency 1 cycle). Decode computed from in_inst before the register.
//  out_valid next = capture ? 1 : (out_ready ? 0 : out_valid). Held beat and
//   all fields stay stable while out_valid && !out_ready.
//  flush: out_valid=0 next edge; the same-cycle incoming beat is dropped.
//   flush takes priority over capture and over out_ready.
//  Decode rules: opcode not in the 10 legal classes -> class ILL, illegal=1.
//   Also illegal: JALR/LOAD/STORE/BRANCH/OP with reserved funct3/funct7;
//   SYSTEM other than ECALL/EBREAK; RVE=1 with any used index bit4 set.
//  out_rd_wen = 1 for LUI/AUIPC/JAL/JALR/LOAD/OPIMM/OP when rd!=0 and not
//   illegal; else 0. rd=x0 never writes.
//  Immediates: 32-bit two's complement sign-extended from inst[31]; B/J bit0=0;
//   U = {inst[31:12],12'b0}.
//  FSM: RUN -> HALT when a beat with out_halt=1 is accepted (out_valid &&
//   out_ready && !flush). HALT: in_ready=0, no capture; leave only via rst.
//   A flushed EBREAK never halts.
// TESTING
//  1 Release rst, out_ready=1 -> out_valid=0, in_ready=1, out_pc=8000_0000.
//  2 in {8000_0000, 0050_0093} (addi x1,x0,5) -> next cycle valid, class 8,
//    rd=1, rs1=0, imm=5, rd_wen=1.
//  3 out_ready=0, two back-to-back beats -> first held stable, in_ready=0;
//    raise out_ready -> second captured next cycle, no loss, no duplicate.
//  4 flush with in_valid=1 and a held beat -> out_valid=0 next cycle; incoming
//    beat never appears.
//  5 in FE00_0EE3 (beq x0,x0,-4) -> class 5, imm=FFFF_FFFC, rd_wen=0.
//    Then 0010_0073 accepted -> out_halt=1; in_ready stays 0 until rst.
//  6 in 0000_0000 -> illegal=1, class 0, rd_wen=0; RVE=1 add x16,x1,x2
//    (0020_8833) -> illegal=1.

Source files
------------

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - RV32I/RV32E decode stage with one-beat holding register and sim-halt FSM
module idu_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter bit                    RVE        = 1'b0,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [3:0]            out_class,
  output logic [2:0]            out_funct3,
  output logic                  out_alt,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic                  out_rd_wen,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_illegal,
  output logic                  out_halt
);

  localparam logic [3:0] C_ILL = 4'd0, C_LUI = 4'd1, C_AUIPC = 4'd2, C_JAL = 4'd3,
                         C_JALR = 4'd4, C_BRANCH = 4'd5, C_LOAD = 4'd6, C_STORE = 4'd7,
                         C_OPIMM = 4'd8, C_OP = 4'd9, C_SYSTEM = 4'd10;

  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t state;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [3:0]            dec_class;
  logic                  dec_bad;
  logic                  dec_illegal;
  logic                  use_rs1, use_rs2, use_rd;
  logic                  rve_bad;
  logic                  dec_rd_wen;
  logic                  dec_halt;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  capture;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  always_comb begin
    dec_class = C_ILL;
    dec_bad   = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    dec_imm   = '0;
    case (opcode)
      7'b0110111: begin
        dec_class = C_LUI;
        use_rd    = 1'b1;
        dec_imm   = {in_inst[31:12], 12'b0};
      end
      7'b0010111: begin
        dec_class = C_AUIPC;
        use_rd    = 1'b1;
        dec_imm   = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_class = C_JAL;
        use_rd    = 1'b1;
        dec_imm   = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        dec_class = C_JALR;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_bad   = (funct3 != 3'b000);
        dec_imm   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b1100011: begin
        dec_class = C_BRANCH;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_bad   = (funct3 == 3'b010) || (funct3 == 3'b011);
        dec_imm   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0000011: begin
        dec_class = C_LOAD;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_bad   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        dec_imm   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec_class = C_STORE;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_bad   = (funct3[2] == 1'b1) || (funct3 == 3'b011);
        dec_imm   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b0010011: begin
        dec_class = C_OPIMM;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_imm   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0110011: begin
        dec_class = C_OP;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rd    = 1'b1;
        // funct7=0100000 only selects SUB (000) and SRA (101)
        dec_bad   = !((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      7'b1110011: begin
        dec_class = C_SYSTEM;
        dec_bad   = (in_inst != 32'h0000_0073) && (in_inst != 32'h0010_0073);
        dec_imm   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      default: dec_bad = 1'b1;
    endcase
  end

  assign rve_bad     = RVE && ((use_rs1 && in_inst[19]) || (use_rs2 && in_inst[24]) ||
                               (use_rd && in_inst[11]));
  assign dec_illegal = dec_bad || rve_bad;
  assign dec_rd_wen  = use_rd && (in_inst[11:7] != 5'd0) && !dec_illegal;
  assign dec_halt    = (in_inst == 32'h0010_0073);

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC;
      out_inst    <= 32'h0000_0013;
      out_class   <= C_ILL;
      out_funct3  <= '0;
      out_alt     <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
      out_halt    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_inst    <= in_inst;
        out_class   <= dec_class;
        out_funct3  <= funct3;
        out_alt     <= in_inst[30];
        out_rs1     <= in_inst[19:15];
        out_rs2     <= in_inst[24:20];
        out_rd      <= in_inst[11:7];
        out_rd_wen  <= dec_rd_wen;
        out_imm     <= dec_imm;
        out_illegal <= dec_illegal;
        out_halt    <= dec_halt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Halt only once EBREAK is actually handed to execute; a flushed one never counts
      if (state == S_RUN && out_valid && out_ready && !flush && out_halt)
        state <= S_HALT;
    end
  end

endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - directed-vector bench for idu_stage (RV32I and RVE instances)
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_alt, out_rd_wen, out_illegal, out_halt;
  logic [31:0] out_pc, out_inst, out_imm;
  logic [3:0]  out_class;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  logic        e_in_ready, e_out_valid, e_out_alt, e_out_rd_wen, e_out_illegal, e_out_halt;
  logic [31:0] e_out_pc, e_out_inst, e_out_imm;
  logic [3:0]  e_out_class;
  logic [2:0]  e_out_funct3;
  logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_class(out_class), .out_funct3(out_funct3),
    .out_alt(out_alt), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_imm(out_imm), .out_illegal(out_illegal), .out_halt(out_halt)
  );

  idu_stage #(.RVE(1'b1)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_out_pc), .out_inst(e_out_inst), .out_class(e_out_class), .out_funct3(e_out_funct3),
    .out_alt(e_out_alt), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
    .out_rd_wen(e_out_rd_wen), .out_imm(e_out_imm), .out_illegal(e_out_illegal),
    .out_halt(e_out_halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: reset state
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_pc", out_pc, 32'h8000_0000);
    check("rst_inst", out_inst, 32'h0000_0013);
    check("rst_class", {28'd0, out_class}, 32'd0);

    // 2: addi x1,x0,5
    drive(1'b1, 32'h8000_0000, 32'h0050_0093);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_class", {28'd0, out_class}, 32'd8);
    check("addi_rd", {27'd0, out_rd}, 32'd1);
    check("addi_rs1", {27'd0, out_rs1}, 32'd0);
    check("addi_imm", out_imm, 32'd5);
    check("addi_wen", {31'd0, out_rd_wen}, 32'd1);
    check("addi_pc", out_pc, 32'h8000_0000);
    tick();
    check("addi_drain", {31'd0, out_valid}, 32'd0);

    // 3: backpressure with two back-to-back beats
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0004, 32'h0020_81B3);
    tick();
    check("bp_a_valid", {31'd0, out_valid}, 32'd1);
    check("bp_a_inst", out_inst, 32'h0020_81B3);
    check("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h8000_0008, 32'h4020_81B3);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_hold_inst", out_inst, 32'h0020_81B3);
      check("bp_hold_pc", out_pc, 32'h8000_0004);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("bp_b_valid", {31'd0, out_valid}, 32'd1);
    check("bp_b_inst", out_inst, 32'h4020_81B3);
    check("bp_b_pc", out_pc, 32'h8000_0008);
    check("bp_b_alt", {31'd0, out_alt}, 32'd1);
    check("bp_b_class", {28'd0, out_class}, 32'd9);
    tick();
    check("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // 4: flush kills held and incoming beat
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_000C, 32'h0050_0093);
    tick();
    check("fl_held", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 32'h8000_0010, 32'h0060_0113);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    check("fl_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    check("fl_valid_stays0", {31'd0, out_valid}, 32'd0);
    check("fl_pc_kept", out_pc, 32'h8000_000C);

    // flushed EBREAK must not halt
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0014, 32'h0010_0073);
    tick();
    check("fl_ebreak_halt", {31'd0, out_halt}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_ebreak_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("fl_ebreak_run", {31'd0, in_ready}, 32'd1);

    // 5: beq x0,x0,-4 then EBREAK
    drive(1'b1, 32'h8000_0020, 32'hFE00_0EE3);
    tick();
    check("beq_class", {28'd0, out_class}, 32'd5);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_wen", {31'd0, out_rd_wen}, 32'd0);
    check("beq_ill", {31'd0, out_illegal}, 32'd0);
    drive(1'b1, 32'h8000_0024, 32'h0010_0073);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("ebr_halt", {31'd0, out_halt}, 32'd1);
    check("ebr_class", {28'd0, out_class}, 32'd10);
    check("ebr_ill", {31'd0, out_illegal}, 32'd0);
    check("ebr_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("halt_in_ready", {31'd0, in_ready}, 32'd0);
    check("halt_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h8000_0028, 32'h0050_0093);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_no_cap", {31'd0, out_valid}, 32'd0);
      check("halt_ready0", {31'd0, in_ready}, 32'd0);
    end
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("rst_unhalt", {31'd0, in_ready}, 32'd1);

    // 6: illegal encodings, RVE, misc decode
    drive(1'b1, 32'h8000_0030, 32'h0000_0000);
    tick();
    check("zero_ill", {31'd0, out_illegal}, 32'd1);
    check("zero_class", {28'd0, out_class}, 32'd0);
    check("zero_wen", {31'd0, out_rd_wen}, 32'd0);
    check("zero_imm", out_imm, 32'd0);
    drive(1'b1, 32'h8000_0034, 32'h0020_8833);
    tick();
    check("rve_ill", {31'd0, e_out_illegal}, 32'd1);
    check("rve_wen", {31'd0, e_out_rd_wen}, 32'd0);
    check("rv32_ill", {31'd0, out_illegal}, 32'd0);
    check("rv32_wen", {31'd0, out_rd_wen}, 32'd1);
    check("rv32_rd", {27'd0, out_rd}, 32'd16);
    drive(1'b1, 32'h8000_0038, 32'h0010_0013);
    tick();
    check("x0_wen", {31'd0, out_rd_wen}, 32'd0);
    check("x0_imm", out_imm, 32'd1);
    drive(1'b1, 32'h8000_003C, 32'h1234_50B7);
    tick();
    check("lui_class", {28'd0, out_class}, 32'd1);
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_wen", {31'd0, out_rd_wen}, 32'd1);

    // asynchronous reset mid-operation discards the held beat
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0040, 32'h0050_0093);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("mid_held", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_pc", out_pc, 32'h8000_0000);
    check("mid_rst_inst", out_inst, 32'h0000_0013);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
